// File: rtl/NetworkPkg.sv
// Shared network-on-chip packet definitions used by ring stages and injectors.
package NetworkPkg;

    localparam int ID_SIZE    = 4;
    localparam int DATA_WIDTH = 128;

    typedef struct packed {
        logic [ID_SIZE-1:0]    src;
        logic [ID_SIZE-1:0]    dest;
        logic [DATA_WIDTH-1:0] data;
    } pkt_t;

endpackage

// File: rtl/ring_inject_arb_pkg.sv
// Arbiter priority state encoding shared by the ring injection arbiter and its bench.
package ring_inject_arb_pkg;

    typedef enum logic {
        PRIO_RING  = 1'b0,
        PRIO_LOCAL = 1'b1
    } arb_state_t;

endpackage

// File: rtl/credit_counter.sv
// Downstream buffer credit counter: starts full, saturates at both ends,
// and latches a sticky overflow when a credit comes back while already full.
module credit_counter #(
    parameter  int MAX = 8,
    localparam int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          overflow
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= CW'(MAX);
            overflow <= 1'b0;
        end else if (inc && !dec) begin
            if (count == CW'(MAX))
                overflow <= 1'b1;
            else
                count <= count + CW'(1);
        end else if (dec && !inc && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/ring_inject_arb.sv
// Ring node injection arbiter: merges through-traffic and local core traffic
// onto the downstream link under credit flow control with anti-starvation.
module ring_inject_arb
    import NetworkPkg::*;
    import ring_inject_arb_pkg::*;
#(
    parameter  int CREDITS      = 8,
    parameter  int STARVE_LIMIT = 4,
    localparam int CW           = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ring_valid,
    input  pkt_t          ring_pkt,
    output logic          ring_ready,
    input  logic          local_valid,
    input  pkt_t          local_pkt,
    output logic          local_ready,
    input  logic          credit_ret,
    output logic          out_valid,
    output pkt_t          out_pkt,
    output logic [CW-1:0] credits,
    output logic          prio_local,
    output logic          err_credit
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t    state;
    logic [SW-1:0] starve;
    logic [SW-1:0] starve_next;
    logic          can_grant;
    logic          ring_gnt;
    logic          local_gnt;
    logic          grant;

    // A credit returned this cycle only becomes usable next cycle.
    always_comb begin
        can_grant = !rst && (credits != '0);
        ring_gnt  = 1'b0;
        local_gnt = 1'b0;
        if (can_grant) begin
            if (state == PRIO_LOCAL) begin
                local_gnt = local_valid;
                ring_gnt  = ring_valid && !local_valid;
            end else begin
                ring_gnt  = ring_valid;
                local_gnt = local_valid && !ring_valid;
            end
        end
    end

    assign grant       = ring_gnt || local_gnt;
    assign ring_ready  = ring_gnt;
    assign local_ready = local_gnt;

    // Losing for lack of credits counts as starvation too.
    always_comb begin
        if (!local_valid || local_gnt)
            starve_next = '0;
        else if (starve == SW'(STARVE_LIMIT))
            starve_next = starve;
        else
            starve_next = starve + SW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= PRIO_RING;
            prio_local <= 1'b0;
            starve     <= '0;
            out_valid  <= 1'b0;
            out_pkt    <= '0;
        end else begin
            starve    <= starve_next;
            out_valid <= grant;
            if (ring_gnt)
                out_pkt <= ring_pkt;
            else if (local_gnt)
                out_pkt <= local_pkt;
            case (state)
                PRIO_RING: begin
                    if (starve_next == SW'(STARVE_LIMIT)) begin
                        state      <= PRIO_LOCAL;
                        prio_local <= 1'b1;
                    end
                end
                PRIO_LOCAL: begin
                    if (local_gnt || !local_valid) begin
                        state      <= PRIO_RING;
                        prio_local <= 1'b0;
                    end
                end
                default: begin
                    state      <= PRIO_RING;
                    prio_local <= 1'b0;
                end
            endcase
        end
    end

    credit_counter #(.MAX(CREDITS)) u_credit_counter (
        .clk      (clk),
        .rst      (rst),
        .inc      (credit_ret),
        .dec      (grant),
        .count    (credits),
        .overflow (err_credit)
    );

endmodule

// File: tb/tb_ring_inject_arb.sv
// Self-checking bench for ring_inject_arb: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_ring_inject_arb;
    import NetworkPkg::*;

    localparam int CREDITS = 8;
    localparam int LIMIT   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       ring_valid;
    pkt_t       ring_pkt;
    logic       ring_ready;
    logic       local_valid;
    pkt_t       local_pkt;
    logic       local_ready;
    logic       credit_ret;
    logic       out_valid;
    pkt_t       out_pkt;
    logic [3:0] credits;
    logic       prio_local;
    logic       err_credit;

    int vectors     = 0;
    int miscompares = 0;

    // behavioural model
    int   m_credits;
    bit   m_prio;
    int   m_starve;
    bit   m_err;
    bit   m_ov;
    pkt_t m_pkt;
    bit   g_ring;
    bit   g_local;

    ring_inject_arb #(.CREDITS(CREDITS), .STARVE_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .ring_valid  (ring_valid),
        .ring_pkt    (ring_pkt),
        .ring_ready  (ring_ready),
        .local_valid (local_valid),
        .local_pkt   (local_pkt),
        .local_ready (local_ready),
        .credit_ret  (credit_ret),
        .out_valid   (out_valid),
        .out_pkt     (out_pkt),
        .credits     (credits),
        .prio_local  (prio_local),
        .err_credit  (err_credit)
    );

    always #5 clk = ~clk;

    function automatic pkt_t rand_pkt();
        pkt_t p;
        p.src  = 4'($urandom);
        p.dest = 4'($urandom);
        p.data = {$urandom, $urandom, $urandom, $urandom};
        return p;
    endfunction

    task automatic model_reset();
        m_credits = CREDITS;
        m_prio    = 1'b0;
        m_starve  = 0;
        m_err     = 1'b0;
        m_ov      = 1'b0;
        m_pkt     = '0;
        g_ring    = 1'b0;
        g_local   = 1'b0;
    endtask

    // Drive one cycle's inputs (called at negedge) and predict the winner.
    task automatic apply(input bit rv, input bit lv, input bit ret, input pkt_t rp, input pkt_t lp);
        ring_valid  = rv;
        local_valid = lv;
        credit_ret  = ret;
        ring_pkt    = rp;
        local_pkt   = lp;
        #1;
        g_ring  = 1'b0;
        g_local = 1'b0;
        if (m_credits > 0) begin
            if (m_prio) begin
                if (lv) g_local = 1'b1;
                else if (rv) g_ring = 1'b1;
            end else begin
                if (rv) g_ring = 1'b1;
                else if (lv) g_local = 1'b1;
            end
        end
    endtask

    // Advance across one rising edge and step the model; returns at negedge.
    task automatic tick();
        int c;
        @(posedge clk);
        m_ov = g_ring || g_local;
        if (g_ring) m_pkt = ring_pkt;
        if (g_local) m_pkt = local_pkt;
        c = m_credits - int'(m_ov) + int'(credit_ret);
        if (c > CREDITS) begin
            c     = CREDITS;
            m_err = 1'b1;
        end
        m_credits = c;
        if (!local_valid || g_local) m_starve = 0;
        else if (m_starve < LIMIT) m_starve = m_starve + 1;
        if (!m_prio) m_prio = (m_starve == LIMIT);
        else if (g_local || !local_valid) m_prio = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        ring_valid  = 1'b0;
        local_valid = 1'b0;
        credit_ret  = 1'b0;
        ring_pkt    = '0;
        local_pkt   = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst         = 1'b1;
        ring_valid  = 1'b1;
        local_valid = 1'b1;
        credit_ret  = 1'b1;
        ring_pkt    = rand_pkt();
        local_pkt   = rand_pkt();
        model_reset();
        #1;
        vectors++;
        if ({ring_ready, local_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 00", {ring_ready, local_ready});
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, credits, prio_local, err_credit} !== {1'b0, 4'd8, 1'b0, 1'b0} || out_pkt !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got ov=%b cr=%0d pl=%b err=%b pkt=%h", out_valid, credits, prio_local, err_credit, out_pkt);
        end
        @(negedge clk);
        ring_valid  = 1'b0;
        local_valid = 1'b0;
        credit_ret  = 1'b0;
        rst         = 1'b0;
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            apply(1'b1, 1'b0, 1'b0, rand_pkt(), rand_pkt());
            vectors++;
            if (ring_ready !== 1'(i < 8) || local_ready !== 1'b0 || ring_ready !== g_ring) begin
                miscompares++;
                $display("FAIL fill_ready[%0d]: got rr=%b lr=%b want rr=%b", i, ring_ready, local_ready, i < 8);
            end
            tick();
            vectors++;
            if (out_valid !== 1'(i < 8) || credits !== 4'((i < 8) ? 7 - i : 0) || out_pkt !== m_pkt) begin
                miscompares++;
                $display("FAIL fill_out[%0d]: got ov=%b cr=%0d want ov=%b cr=%0d", i, out_valid, credits, i < 8, (i < 8) ? 7 - i : 0);
            end
        end
    endtask

    task automatic test_rotation();
        bit exp_local;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            apply(1'b1, 1'b1, 1'b1, rand_pkt(), rand_pkt());
            exp_local = (i % 5 == 4);
            vectors++;
            if (prio_local !== exp_local || local_ready !== exp_local || ring_ready !== !exp_local || local_ready !== g_local) begin
                miscompares++;
                $display("FAIL rotation[%0d]: got pl=%b lr=%b rr=%b want pl=%b lr=%b", i, prio_local, local_ready, ring_ready, exp_local, exp_local);
            end
            tick();
            vectors++;
            if (credits !== 4'd8 || out_valid !== 1'b1 || out_pkt !== m_pkt || err_credit !== 1'b0) begin
                miscompares++;
                $display("FAIL rotation_out[%0d]: got cr=%0d ov=%b err=%b pkt=%h want cr=8 pkt=%h", i, credits, out_valid, err_credit, out_pkt, m_pkt);
            end
        end
    endtask

    task automatic test_starve_credit();
        pkt_t lp;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 1'b0, 1'b0, rand_pkt(), rand_pkt());
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 1'b1, 1'b0, rand_pkt(), rand_pkt());
            vectors++;
            if ({ring_ready, local_ready} !== 2'b00) begin
                miscompares++;
                $display("FAIL starve_nocredit[%0d]: got %b want 00", i, {ring_ready, local_ready});
            end
            tick();
        end
        vectors++;
        if (prio_local !== 1'b1 || credits !== 4'd0) begin
            miscompares++;
            $display("FAIL starve_prio: got pl=%b cr=%0d want pl=1 cr=0", prio_local, credits);
        end
        apply(1'b1, 1'b1, 1'b1, rand_pkt(), rand_pkt());
        vectors++;
        if ({ring_ready, local_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL starve_ret_cycle: got %b want 00", {ring_ready, local_ready});
        end
        tick();
        lp = rand_pkt();
        apply(1'b1, 1'b1, 1'b0, rand_pkt(), lp);
        vectors++;
        if ({ring_ready, local_ready} !== 2'b01 || credits !== 4'd1) begin
            miscompares++;
            $display("FAIL starve_grant: got rr/lr=%b cr=%0d want 01 cr=1", {ring_ready, local_ready}, credits);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_pkt !== lp || credits !== 4'd0 || prio_local !== 1'b0) begin
            miscompares++;
            $display("FAIL starve_out: got ov=%b cr=%0d pl=%b pkt=%h want pkt=%h", out_valid, credits, prio_local, out_pkt, lp);
        end
        apply(1'b1, 1'b1, 1'b0, rand_pkt(), rand_pkt());
        vectors++;
        if ({ring_ready, local_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL starve_single: got %b want 00", {ring_ready, local_ready});
        end
        tick();
    endtask

    task automatic test_credit_edges();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b0, 1'b0, rand_pkt(), rand_pkt());
            tick();
        end
        apply(1'b1, 1'b0, 1'b1, rand_pkt(), rand_pkt());
        tick();
        vectors++;
        if (credits !== 4'd3 || err_credit !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL credit_same_cycle: got cr=%0d err=%b ov=%b want cr=3 err=0 ov=1", credits, err_credit, out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, 1'b1, rand_pkt(), rand_pkt());
            tick();
        end
        vectors++;
        if (credits !== 4'd8 || err_credit !== 1'b0) begin
            miscompares++;
            $display("FAIL credit_refill: got cr=%0d err=%b want cr=8 err=0", credits, err_credit);
        end
        apply(1'b0, 1'b0, 1'b1, rand_pkt(), rand_pkt());
        tick();
        vectors++;
        if (credits !== 4'd8 || err_credit !== 1'b1) begin
            miscompares++;
            $display("FAIL credit_overflow: got cr=%0d err=%b want cr=8 err=1", credits, err_credit);
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 1'b0, rand_pkt(), rand_pkt());
            tick();
        end
        vectors++;
        if (err_credit !== 1'b1 || credits !== 4'd5) begin
            miscompares++;
            $display("FAIL credit_sticky: got err=%b cr=%0d want err=1 cr=5", err_credit, credits);
        end
    endtask

    task automatic test_async_reset();
        pkt_t p;
        do_reset();
        apply(1'b1, 1'b0, 1'b0, rand_pkt(), rand_pkt());
        tick();
        vectors++;
        if (out_valid !== 1'b1 || credits !== 4'd7) begin
            miscompares++;
            $display("FAIL async_pre: got ov=%b cr=%0d want ov=1 cr=7", out_valid, credits);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (out_valid !== 1'b0 || credits !== 4'd8 || {ring_ready, local_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL async_assert: got ov=%b cr=%0d rdy=%b want ov=0 cr=8 rdy=00", out_valid, credits, {ring_ready, local_ready});
        end
        ring_valid = 1'b0;
        #1;
        rst = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || credits !== 4'd8) begin
            miscompares++;
            $display("FAIL async_replay: got ov=%b cr=%0d want ov=0 cr=8", out_valid, credits);
        end
        p = rand_pkt();
        apply(1'b1, 1'b0, 1'b0, p, rand_pkt());
        vectors++;
        if (ring_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_first_ready: got %b want 1", ring_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_pkt !== p) begin
            miscompares++;
            $display("FAIL async_first_out: got ov=%b pkt=%h want ov=1 pkt=%h", out_valid, out_pkt, p);
        end
    endtask

    task automatic test_local_pkt();
        pkt_t p;
        do_reset();
        p = '{src: 4'd0, dest: 4'd2, data: 128'h1234};
        apply(1'b0, 1'b1, 1'b0, rand_pkt(), p);
        vectors++;
        if ({ring_ready, local_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL local_ready: got %b want 01", {ring_ready, local_ready});
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_pkt !== p) begin
            miscompares++;
            $display("FAIL local_out: got ov=%b pkt=%h want ov=1 pkt=%h", out_valid, out_pkt, p);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4),
                  rand_pkt(), rand_pkt());
            vectors++;
            if (ring_ready !== g_ring || local_ready !== g_local) begin
                miscompares++;
                $display("FAIL rand_ready[%0d]: got rr=%b lr=%b want rr=%b lr=%b", i, ring_ready, local_ready, g_ring, g_local);
            end
            tick();
            vectors++;
            if (out_valid !== m_ov || credits !== 4'(m_credits) || prio_local !== m_prio ||
                err_credit !== m_err || out_pkt !== m_pkt) begin
                miscompares++;
                $display("FAIL rand_state[%0d]: got ov=%b cr=%0d pl=%b err=%b want ov=%b cr=%0d pl=%b err=%b",
                         i, out_valid, credits, prio_local, err_credit, m_ov, m_credits, m_prio, m_err);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        ring_valid  = 1'b0;
        local_valid = 1'b0;
        credit_ret  = 1'b0;
        ring_pkt    = '0;
        local_pkt   = '0;
        model_reset();
        test_reset();
        test_fill();
        test_rotation();
        test_starve_credit();
        test_credit_edges();
        test_async_reset();
        test_local_pkt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
